dm_unit: RTL and testbench
==========================

# dm_unit

Data-memory unit on the MEM-stage side of the pipelined CPU. It consumes the CPU's memory address, store data, read/write strobes and access type, and returns formatted load data to the MEM/WB register. It covers RV32I byte, halfword and word access with byte-lane writes and sign/zero extension. It also keeps a sticky misalignment fault record and load/store access counters for debug.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two.
- `ADDR_W`, default `$clog2(DEPTH_WORDS)`: word-index width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_w`  in  1  store strobe from MEM stage.
- `mem_r`  in  1  load strobe from MEM stage.
- `addr`  in  32  byte address (CPU `Addr_out`).
- `din`  in  32  store data (CPU `Data_out`); the low bytes are used for sb/sh.
- `dm_type`  in  3  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned; any other value is treated as word.
- `dout`  out  32  formatted load data (CPU `Data_in`).
- `misalign`  out  1  combinational flag: the current access is misaligned.
- `fault`  out  1  sticky fault flag.
- `fault_addr`  out  32  address of the first faulting access.
- `fault_clr`  in  1  clears `fault` and `fault_addr`.
- `load_cnt`  out  16  completed loads.
- `store_cnt`  out  16  completed stores.

## Operation
- Storage: `DEPTH_WORDS` x 32 array. Word index = `addr[ADDR_W+1:2]`. Upper address bits are ignored, so accesses wrap modulo the array size.
- Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
- Store byte enables:
  - word: 4'b1111.
  - half: 4'b0011 when `addr[1]`=0, else 4'b1100. The data is `din[15:0]` replicated into the selected lanes.
  - byte: one-hot on `addr[1:0]`. The data is `din[7:0]` placed into the selected lane.
- Stores: enabled lanes are written on the rising edge when `mem_w`=1; disabled lanes are unchanged.
- Loads: `dout` is a combinational read of the addressed word, shifted by lane.
  - Sign-extended for types 001 and 011; zero-extended for 010 and 100.
  - `dout`=0 whenever `mem_r`=0.
- `misalign` rules:
  - word access: set when `addr[1:0]`≠0.
  - half access: set when `addr[0]`=1.
  - byte access: never set.
  - Asserted only while `mem_r` or `mem_w` is high.
- Counters: `load_cnt` increments on each edge with an accepted load; `store_cnt` increments on each edge with an accepted store. Both wrap at 16 bits.
- A suppressed access (see Configuration) is not counted.
- Both `mem_r` and `mem_w` asserted in the same cycle:
  - The store is performed.
  - `dout` shows the pre-write contents.
  - Both counters increment.

## Timing
- Load latency is 0 cycles: `dout` is combinational from `addr`/`dm_type`/`mem_r` and the array. This matches the CPU sampling `Data_in` into MEM/WB on the opposite clock phase.
- Store latency is 1 edge: written data is visible to a load in the following cycle.
- Reset, applied synchronously on a rising edge with `reset`=1:
  - The array is cleared to 0.
  - `fault`=0, `fault_addr`=0, `load_cnt`=0, `store_cnt`=0.
  - Stores are ignored during reset.
- Reset applied mid-sequence discards any store presented in the same cycle.
- Fault register:
  - On an edge with a misaligned access and `fault`=0, set `fault`=1 and capture `fault_addr`=`addr`.
  - Later faults do not overwrite `fault_addr` until it is cleared.
  - `fault_clr`=1 clears both on the next edge.
  - If a new fault coincides with `fault_clr`, the new fault wins: `fault`=1 and `fault_addr` = the new address.
- Reset values of all outputs: `dout`=0 (with `mem_r` low), `misalign`=0, `fault`=0, `fault_addr`=0, `load_cnt`=0, `store_cnt`=0.

## Configuration
- Macro `DM_ALIGN_CHECK_EN`.
- Defined:
  - A misaligned store is suppressed (no lanes written, not counted).
  - A misaligned load returns `dout`=0 and is not counted.
  - `misalign`, `fault` and `fault_addr` behave as described above.
- Undefined:
  - No alignment checking. `addr` low bits are forced to natural alignment: `addr[1:0]` ignored for word, `addr[0]` ignored for half.
  - All accesses proceed and are counted.
  - `misalign`, `fault` and `fault_addr` are tied to 0, and `fault_clr` is ignored.

## Test plan
- Reset, then word read: assert `reset` 1 cycle, load from 0x40 -> `dout`=0, `load_cnt`=1.
- Word store/load: sw 0xDEADBEEF at 0x10, then lw 0x10 -> `dout`=0xDEADBEEF, `store_cnt`=1, `load_cnt`=1.
- Byte lanes: sw 0x11223344 at 0x20, sb 0xAA at 0x22, then:
  - lw 0x20 -> 0x11AA3344.
  - lb 0x22 -> 0xFFFFFFAA.
  - lbu 0x22 -> 0x000000AA.
- Halfword: sh 0x8001 at 0x32, then:
  - lh 0x32 -> 0xFFFF8001.
  - lhu 0x32 -> 0x00008001.
  - lw 0x30 -> 0x8001_xxxx, where the low half is unchanged.
- Alignment with `DM_ALIGN_CHECK_EN` defined:
  - sw at 0x13 -> no write, `fault`=1, `fault_addr`=0x13.
  - lh at 0x15 -> `dout`=0, `fault_addr` stays 0x13.
  - Pulse `fault_clr` -> `fault`=0.
  - Without the macro, sw at 0x13 writes word 0x10.
- Wrap and simultaneous events:
  - sw at byte address 4*`DEPTH_WORDS`+4 -> word 1 is written.
  - `mem_r` and `mem_w` together -> `dout` shows the old value and the new value reads next cycle.
  - 65536 stores -> `store_cnt` wraps to 0.

Source files
------------

// File: rtl/dm_unit.sv
// ---------------------------------------------------------------------------
// dm_unit - MEM-stage data memory for an RV32I pipeline.
//
// Handles word / halfword / byte loads and stores with byte-lane write
// enables, sign or zero extension on loads, a sticky misalignment fault
// record and free-running load/store counters for debug.
//
// Optional feature macro: DM_ALIGN_CHECK_EN
//   defined   : misaligned accesses are flagged, suppressed (no write, zero
//               load data, not counted) and recorded in fault/fault_addr.
//   undefined : low address bits are forced to natural alignment, every
//               access proceeds, misalign/fault/fault_addr are tied to 0.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two)
//   ADDR_W      : word-index width
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset
//   mem_w       in   store strobe
//   mem_r       in   load strobe
//   addr        in   byte address (upper bits beyond the array wrap)
//   din         in   store data (low bytes used for sb/sh)
//   dm_type     in   000 word, 001 half, 010 half-u, 011 byte, 100 byte-u
//   dout        out  formatted load data, combinational, 0 when mem_r=0
//   misalign    out  current access is misaligned (combinational)
//   fault       out  sticky misalignment fault
//   fault_addr  out  address of the first recorded fault
//   fault_clr   in   clears fault and fault_addr on the next edge
//   load_cnt    out  accepted loads, wraps at 16 bits
//   store_cnt   out  accepted stores, wraps at 16 bits
// ---------------------------------------------------------------------------
module dm_unit #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_w,
   input  logic        mem_r,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   input  logic [2:0]  dm_type,
   output logic [31:0] dout,
   output logic        misalign,
   output logic        fault,
   output logic [31:0] fault_addr,
   input  logic        fault_clr,
   output logic [15:0] load_cnt,
   output logic [15:0] store_cnt
);

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_t;

   size_t             size_s;
   logic              sign_ext_s;
   logic              misalign_raw_s;
   logic              misalign_s;
   logic              suppress_s;
   logic [1:0]        lane_s;
   logic [ADDR_W-1:0] word_idx_s;
   logic [3:0]        be_s;
   logic [31:0]       wdata_s;
   logic [31:0]       rd_word_s;
   logic [31:0]       shifted_s;
   logic [31:0]       load_data_s;
   logic              store_ok_s;
   logic              load_ok_s;
   logic              unused_s;

   logic [31:0]       mem_array_r [DEPTH_WORDS];
   logic [15:0]       load_cnt_r;
   logic [15:0]       store_cnt_r;
   logic              fault_r;
   logic [31:0]       fault_addr_r;

   // Upper address bits are intentionally ignored so accesses wrap.
   assign word_idx_s = addr[ADDR_W+1:2];

   // Decode access size and extension mode; unknown encodings act as word.
   always_comb begin
      size_s     = SZ_WORD;
      sign_ext_s = 1'b0;
      case (dm_type)
         3'b000: begin size_s = SZ_WORD; sign_ext_s = 1'b0; end
         3'b001: begin size_s = SZ_HALF; sign_ext_s = 1'b1; end
         3'b010: begin size_s = SZ_HALF; sign_ext_s = 1'b0; end
         3'b011: begin size_s = SZ_BYTE; sign_ext_s = 1'b1; end
         3'b100: begin size_s = SZ_BYTE; sign_ext_s = 1'b0; end
         default: begin size_s = SZ_WORD; sign_ext_s = 1'b0; end
      endcase
   end

   // Raw alignment test, independent of whether an access is requested.
   always_comb begin
      misalign_raw_s = 1'b0;
      case (size_s)
         SZ_WORD: misalign_raw_s = (addr[1:0] != 2'b00);
         SZ_HALF: misalign_raw_s = addr[0];
         SZ_BYTE: misalign_raw_s = 1'b0;
         default: misalign_raw_s = 1'b0;
      endcase
   end

`ifdef DM_ALIGN_CHECK_EN
   // Misaligned accesses are blocked, so the raw lane can be used directly.
   assign lane_s     = addr[1:0];
   assign misalign_s = (mem_r | mem_w) & misalign_raw_s;
   assign suppress_s = misalign_s;
   assign unused_s   = ^{addr[31:ADDR_W+2]};
`else
   // Without checking, force the lane to the natural alignment of the size.
   always_comb begin
      lane_s = 2'b00;
      case (size_s)
         SZ_WORD: lane_s = 2'b00;
         SZ_HALF: lane_s = {addr[1], 1'b0};
         SZ_BYTE: lane_s = addr[1:0];
         default: lane_s = 2'b00;
      endcase
   end
   assign misalign_s = 1'b0;
   assign suppress_s = 1'b0;
   assign unused_s   = ^{addr[31:ADDR_W+2], fault_clr, misalign_raw_s};
`endif

   assign store_ok_s = mem_w & ~suppress_s;
   assign load_ok_s  = mem_r & ~suppress_s;

   // Byte enables and lane-replicated write data for the store path.
   always_comb begin
      be_s    = 4'b0000;
      wdata_s = din;
      case (size_s)
         SZ_WORD: begin
            be_s    = 4'b1111;
            wdata_s = din;
         end
         SZ_HALF: begin
            be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
            wdata_s = {din[15:0], din[15:0]};
         end
         SZ_BYTE: begin
            be_s    = 4'b0001 << lane_s;
            wdata_s = {4{din[7:0]}};
         end
         default: begin
            be_s    = 4'b1111;
            wdata_s = din;
         end
      endcase
   end

   // Asynchronous read of the addressed word; the selected lane is moved
   // down to bit 0 before extension.
   assign rd_word_s = mem_array_r[word_idx_s];
   assign shifted_s = rd_word_s >> {lane_s, 3'b000};

   // Size-dependent sign or zero extension of the load data.
   always_comb begin
      load_data_s = 32'd0;
      case (size_s)
         SZ_WORD: load_data_s = rd_word_s;
         SZ_HALF: begin
            if (sign_ext_s) begin
               load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end else begin
               load_data_s = {16'd0, shifted_s[15:0]};
            end
         end
         SZ_BYTE: begin
            if (sign_ext_s) begin
               load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end else begin
               load_data_s = {24'd0, shifted_s[7:0]};
            end
         end
         default: load_data_s = rd_word_s;
      endcase
   end

   // The CPU samples this on the opposite clock phase, so it stays
   // combinational; with a simultaneous store it shows the pre-write word.
   assign dout     = load_ok_s ? load_data_s : 32'd0;
   assign misalign = misalign_s;

   // Storage array: cleared by reset, byte-lane writes on accepted stores.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_array_r[i[ADDR_W-1:0]] <= 32'd0;
         end
      end else if (store_ok_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b[1:0]]) begin
               mem_array_r[word_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
            end
         end
      end
   end

   // Debug counters of accepted loads and stores, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_cnt_r  <= 16'd0;
         store_cnt_r <= 16'd0;
      end else begin
         if (load_ok_s) begin
            load_cnt_r <= load_cnt_r + 16'd1;
         end
         if (store_ok_s) begin
            store_cnt_r <= store_cnt_r + 16'd1;
         end
      end
   end

   assign load_cnt  = load_cnt_r;
   assign store_cnt = store_cnt_r;

`ifdef DM_ALIGN_CHECK_EN
   // Sticky fault record: the first fault is kept until cleared, but a
   // fault arriving together with a clear re-arms with the new address.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_r      <= 1'b0;
         fault_addr_r <= 32'd0;
      end else if (misalign_s && (!fault_r || fault_clr)) begin
         fault_r      <= 1'b1;
         fault_addr_r <= addr;
      end else if (fault_clr) begin
         fault_r      <= 1'b0;
         fault_addr_r <= 32'd0;
      end
   end
`else
   assign fault_r      = 1'b0;
   assign fault_addr_r = 32'd0;
`endif

   assign fault      = fault_r;
   assign fault_addr = fault_addr_r;

endmodule

// File: tb/tb_dm_unit.sv
// ---------------------------------------------------------------------------
// tb_dm_unit - self-checking bench for dm_unit.
// Directed scenarios followed by randomized traffic, compared against a
// byte-addressed reference model of the memory, counters and fault record.
// ---------------------------------------------------------------------------
module tb_dm_unit;

   localparam int DEPTH  = 64;
   localparam int NBYTES = 4 * DEPTH;
`ifdef DM_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_w = 1'b0;
   logic        mem_r = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] din = 32'd0;
   logic [2:0]  dm_type = 3'd0;
   logic [31:0] dout;
   logic        misalign;
   logic        fault;
   logic [31:0] fault_addr;
   logic        fault_clr = 1'b0;
   logic [15:0] load_cnt;
   logic [15:0] store_cnt;

   dm_unit #(.DEPTH_WORDS(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_w      (mem_w),
      .mem_r      (mem_r),
      .addr       (addr),
      .din        (din),
      .dm_type    (dm_type),
      .dout       (dout),
      .misalign   (misalign),
      .fault      (fault),
      .fault_addr (fault_addr),
      .fault_clr  (fault_clr),
      .load_cnt   (load_cnt),
      .store_cnt  (store_cnt)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;

   // reference model state
   logic [7:0]  mb [NBYTES];
   logic [15:0] lc_m = 16'd0;
   logic [15:0] sc_m = 16'd0;
   logic        fault_m = 1'b0;
   logic [31:0] fa_m = 32'd0;
   logic [31:0] last_dout = 32'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] t);
      case (t)
         3'b001, 3'b010: return 2;
         3'b011, 3'b100: return 1;
         default:        return 4;
      endcase
   endfunction

   function automatic int bidx(input logic [31:0] ba);
      return int'(ba & 32'(NBYTES - 1));
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a);
      int          n;
      logic [31:0] ea;
      logic [31:0] v;
      n  = acc_size(t);
      ea = a & ~32'(n - 1);
      v  = 32'd0;
      for (int k = 0; k < n; k++) begin
         v = v | ({24'd0, mb[bidx(ea + 32'(k))]} << (8 * k));
      end
      if (t == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      if (t == 3'b011 && v[7])  v = v | 32'hFFFF_FF00;
      return v;
   endfunction

   task automatic model_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
      int          n;
      logic [31:0] ea;
      n  = acc_size(t);
      ea = a & ~32'(n - 1);
      for (int k = 0; k < n; k++) begin
         mb[bidx(ea + 32'(k))] = d[8*k +: 8];
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NBYTES; i++) mb[i] = 8'd0;
      lc_m    = 16'd0;
      sc_m    = 16'd0;
      fault_m = 1'b0;
      fa_m    = 32'd0;
   endtask

   task automatic check_state();
      check("load_cnt", {16'd0, load_cnt}, {16'd0, lc_m});
      check("store_cnt", {16'd0, store_cnt}, {16'd0, sc_m});
      check("fault", {31'd0, fault}, {31'd0, fault_m});
      check("fault_addr", fault_addr, fa_m);
   endtask

   // One access cycle: drive at negedge, check combinational outputs,
   // advance the model, then check registered state after the edge.
   task automatic do_op(input logic w, input logic r, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d, input logic clr);
      logic        mis;
      logic [31:0] exp_dout;
      @(negedge clk);
      mem_w = w; mem_r = r; dm_type = t; addr = a; din = d; fault_clr = clr;
      #1;
      mis      = ALIGN_EN && (w || r) && ((a % 32'(acc_size(t))) != 32'd0);
      exp_dout = (r && !mis) ? model_load(t, a) : 32'd0;
      last_dout = dout;
      check("dout", dout, exp_dout);
      check("misalign", {31'd0, misalign}, {31'd0, mis});
      if (w && !mis) begin
         model_store(t, a, d);
         sc_m++;
      end
      if (r && !mis) lc_m++;
      if (mis && (!fault_m || clr)) begin
         fault_m = 1'b1;
         fa_m    = a;
      end else if (clr && ALIGN_EN) begin
         fault_m = 1'b0;
         fa_m    = 32'd0;
      end
      @(posedge clk);
      #1;
      check_state();
   endtask

   // Reset cycle with a store presented; the store must be discarded.
   task automatic do_reset(input logic [31:0] a);
      @(negedge clk);
      reset = 1'b1; mem_w = 1'b1; mem_r = 1'b0; dm_type = 3'b000;
      addr = a; din = $urandom | 32'h1; fault_clr = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      check_state();
      @(negedge clk);
      reset = 1'b0; mem_w = 1'b0; mem_r = 1'b0;
      #1;
      check("dout_idle", dout, 32'd0);
      check("misalign_idle", {31'd0, misalign}, 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  t;

      model_reset();
      // reset then word read from an address stored during reset
      do_reset(32'h40);
      do_op(1'b0, 1'b1, 3'b000, 32'h40, 32'd0, 1'b0);
      check("rst_lw", last_dout, 32'd0);
      check("rst_lcnt", {16'd0, load_cnt}, 32'd1);

      // word store / load
      do_op(1'b1, 1'b0, 3'b000, 32'h10, 32'hDEAD_BEEF, 1'b0);
      do_op(1'b0, 1'b1, 3'b000, 32'h10, 32'd0, 1'b0);
      check("lw_10", last_dout, 32'hDEAD_BEEF);
      check("scnt_1", {16'd0, store_cnt}, 32'd1);

      // byte lanes
      do_op(1'b1, 1'b0, 3'b000, 32'h20, 32'h1122_3344, 1'b0);
      do_op(1'b1, 1'b0, 3'b011, 32'h22, 32'h1234_56AA, 1'b0);
      do_op(1'b0, 1'b1, 3'b000, 32'h20, 32'd0, 1'b0);
      check("lw_20", last_dout, 32'h11AA_3344);
      do_op(1'b0, 1'b1, 3'b011, 32'h22, 32'd0, 1'b0);
      check("lb_22", last_dout, 32'hFFFF_FFAA);
      do_op(1'b0, 1'b1, 3'b100, 32'h22, 32'd0, 1'b0);
      check("lbu_22", last_dout, 32'h0000_00AA);

      // halfword
      do_op(1'b1, 1'b0, 3'b000, 32'h30, 32'h5555_7777, 1'b0);
      do_op(1'b1, 1'b0, 3'b001, 32'h32, 32'hABCD_8001, 1'b0);
      do_op(1'b0, 1'b1, 3'b001, 32'h32, 32'd0, 1'b0);
      check("lh_32", last_dout, 32'hFFFF_8001);
      do_op(1'b0, 1'b1, 3'b010, 32'h32, 32'd0, 1'b0);
      check("lhu_32", last_dout, 32'h0000_8001);
      do_op(1'b0, 1'b1, 3'b000, 32'h30, 32'd0, 1'b0);
      check("lw_30", last_dout, 32'h8001_7777);

      // alignment behaviour (expectations depend on the build)
      do_op(1'b1, 1'b0, 3'b000, 32'h13, 32'hCAFE_F00D, 1'b0);
      check("sw13_fault", {31'd0, fault}, {31'd0, ALIGN_EN});
      check("sw13_faddr", fault_addr, ALIGN_EN ? 32'h13 : 32'h0);
      do_op(1'b0, 1'b1, 3'b000, 32'h10, 32'd0, 1'b0);
      check("sw13_word10", last_dout, ALIGN_EN ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
      do_op(1'b0, 1'b1, 3'b001, 32'h15, 32'd0, 1'b0);
      check("lh15_faddr", fault_addr, ALIGN_EN ? 32'h13 : 32'h0);
      do_op(1'b0, 1'b0, 3'b000, 32'h0, 32'd0, 1'b1);
      check("clr_fault", {31'd0, fault}, 32'd0);
      // new fault coinciding with a clear wins
      do_op(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
      do_op(1'b0, 1'b1, 3'b000, 32'h21, 32'd0, 1'b1);
      check("clr_newfault", fault_addr, ALIGN_EN ? 32'h21 : 32'h0);
      do_op(1'b0, 1'b0, 3'b000, 32'h0, 32'd0, 1'b1);

      // address wrap
      do_op(1'b1, 1'b0, 3'b000, 32'(4 * DEPTH + 4), 32'h0BAD_F00D, 1'b0);
      do_op(1'b0, 1'b1, 3'b000, 32'h4, 32'd0, 1'b0);
      check("wrap_w1", last_dout, 32'h0BAD_F00D);

      // simultaneous load and store
      do_op(1'b1, 1'b0, 3'b000, 32'h50, 32'h1111_1111, 1'b0);
      do_op(1'b1, 1'b1, 3'b000, 32'h50, 32'h2222_2222, 1'b0);
      check("rw_old", last_dout, 32'h1111_1111);
      do_op(1'b0, 1'b1, 3'b000, 32'h50, 32'd0, 1'b0);
      check("rw_new", last_dout, 32'h2222_2222);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset($urandom & 32'hFC);
         end else begin
            a = $urandom & 32'hFF;
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FF00);
            t = 3'($urandom_range(0, 7));
            do_op(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), t, a,
                  $urandom, 1'($urandom_range(0, 15) == 0));
         end
      end

      // store counter wrap
      do_reset(32'h0);
      @(negedge clk);
      mem_w = 1'b1; mem_r = 1'b0; dm_type = 3'b000; addr = 32'h0; fault_clr = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         din = $urandom;
         model_store(3'b000, 32'h0, din);
         sc_m++;
         @(negedge clk);
      end
      check("scnt_ffff", {16'd0, store_cnt}, 32'h0000_FFFF);
      din = $urandom;
      model_store(3'b000, 32'h0, din);
      sc_m++;
      @(negedge clk);
      check("scnt_wrap", {16'd0, store_cnt}, {16'd0, sc_m});
      check("scnt_zero", {16'd0, store_cnt}, 32'd0);
      mem_w = 1'b0;
      do_op(1'b0, 1'b1, 3'b000, 32'h0, 32'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
